rs232_tx_gen: RTL and testbench

//  Serial transmitter for the console line. Drives the design's rs232_rx input

---
 rtl/rs232_tx_gen.sv | 185 ++++++++++++++++++
 tb/tb_rs232_tx_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_gen.sv
// rtl/rs232_tx_gen.sv - FIFO-fed asynchronous 8-bit serial transmitter (start, 8 data LSB first, optional parity, stop)
module rs232_tx_gen #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 3,
    parameter int PARITY  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    input  logic [7:0]         wr_data,
    output logic               wr_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0]      BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;

    state_t             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;

    logic               push;
    logic               pop;
    logic               baud_tick;
    logic [7:0]         head;

    assign wr_ready   = (count_q != CNT_FULL);
    assign push       = wr_valid & wr_ready;
    assign head       = fifo_mem[rd_ptr_q];
    assign baud_tick  = (baud_q == BAUD_LAST);
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) | (count_q != '0);
    assign fifo_count = count_q;

    // Storage array carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + BAUD_ONE;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_PAR: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Loading a new frame is shared by the idle start and the back-to-back stop-end path.
        if (pop) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = 3'd0;
            shift_d = head;
            par_d   = (PARITY == 2) ? ~(^head) : (^head);
            tx_d    = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_rs232_tx_gen.sv
// tb/tb_rs232_tx_gen.sv - directed scoreboard bench for rs232_tx_gen (CLK_DIV=4, no parity and odd parity instances)
module tb_rs232_tx_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;

    logic       p_wr_valid;
    logic [7:0] p_wr_data;
    logic       p_wr_ready;
    logic       p_tx;
    logic       p_busy;
    logic [3:0] p_fifo_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb [$];
    int         frames_seen = 0;

    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;

    rs232_tx_gen #(.CLK_DIV(4), .FIFO_AW(3), .PARITY(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    rs232_tx_gen #(.CLK_DIV(4), .FIFO_AW(3), .PARITY(2)) dut_p (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (p_wr_valid),
        .wr_data    (p_wr_data),
        .wr_ready   (p_wr_ready),
        .tx         (p_tx),
        .busy       (p_busy),
        .fifo_count (p_fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level k edges after the push edge, for a frame pushed into an idle transmitter with CLK_DIV=4.
    function automatic logic exp_tx(input logic [7:0] d, input int k, input int par_mode);
        if (k >= 1 && k <= 4) return 1'b0;
        if (k >= 5 && k <= 36) return d[(k - 5) / 4];
        if (k >= 37 && k <= 40 && par_mode == 1) return ^d;
        if (k >= 37 && k <= 40 && par_mode == 2) return ~(^d);
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy !== 1'b0; i++) step();
        check(tag, busy, 0);
    endtask

    task automatic send_and_check(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        sb.push_back(d);
        step();
        wr_valid = 1'b0;
        wr_data  = 8'hXX;
        check("push_count", fifo_count, 1);
        check("push_tx_idle", tx, 1);
        for (int k = 1; k <= 44; k++) begin
            step();
            check($sformatf("frame%02h_tx_k%0d", d, k), tx, exp_tx(d, k, 0));
            check($sformatf("frame%02h_busy_k%0d", d, k), busy, (k <= 40) ? 1 : 0);
            if (k == 1) check("pop_count", fifo_count, 0);
        end
    endtask

    // Serial decoder: samples mid-bit on the falling edge and scores each completed frame.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            mon_active = 1'b0;
            sb.delete();
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2) begin
                check("mon_start", tx, 0);
            end else if (mon_cnt % 4 == 2 && mon_cnt < 36) begin
                mon_byte[mon_cnt / 4 - 1] = tx;
            end else if (mon_cnt == 38) begin
                check("mon_stop", tx, 1);
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL mon_unexpected_frame: observed %02h expected no frame", mon_byte);
                end
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    check("mon_byte", mon_byte, mon_exp);
                end
                frames_seen++;
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        p_wr_valid = 1'b0;
        p_wr_data  = 8'h00;
        step();
        step();
        reset = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", wr_ready, 1);
        step();

        // T1: single byte, full waveform
        send_and_check(8'h55);
        step();

        // T2: two bytes on consecutive edges, second start exactly 40 clk later
        wr_valid = 1'b1;
        wr_data  = 8'h41;
        sb.push_back(8'h41);
        step();
        check("t2_count_e", fifo_count, 1);
        wr_data = 8'h0D;
        sb.push_back(8'h0D);
        step();
        wr_valid = 1'b0;
        check("t2_count_e1", fifo_count, 1);
        check("t2_first_start", tx, 0);
        for (int k = 2; k <= 40; k++) step();
        check("t2_stop_before_second", tx, 1);
        check("t2_count_e40", fifo_count, 1);
        step();
        check("t2_second_start", tx, 0);
        check("t2_count_e41", fifo_count, 0);
        wait_idle("t2_idle", 200);
        step();

        // T3: hold wr_valid for 12 edges; 9 accepted
        for (int i = 0; i < 12; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hA0 + 8'(i);
            check($sformatf("t3_ready_%0d", i), wr_ready, (i < 9) ? 1 : 0);
            if (i < 9) sb.push_back(8'hA0 + 8'(i));
            step();
        end
        wr_valid = 1'b0;
        check("t3_full_count", fifo_count, 8);
        check("t3_full_ready", wr_ready, 0);

        // T6: push attempt on the stop-end pop edge while full
        for (int k = 12; k <= 40; k++) step();
        check("t6_pre_count", fifo_count, 8);
        check("t6_pre_tx", tx, 1);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        check("t6_pre_ready", wr_ready, 0);
        step();
        wr_valid = 1'b0;
        check("t6_post_count", fifo_count, 7);
        check("t6_post_ready", wr_ready, 1);
        check("t6_next_start", tx, 0);
        wait_idle("t3_drain_idle", 600);
        check("t3_sb_empty", sb.size(), 0);
        step();

        // T4: reset during DATA bit 3, then a clean frame
        wr_valid = 1'b1;
        wr_data  = 8'hC3;
        sb.push_back(8'hC3);
        step();
        wr_valid = 1'b0;
        for (int k = 1; k <= 18; k++) step();
        check("t4_bit3_low", tx, 0);
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        wr_valid = 1'b0;
        check("t4_rst_tx", tx, 1);
        check("t4_rst_count", fifo_count, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_ready", wr_ready, 1);
        step();
        check("t4_post_tx", tx, 1);
        check("t4_post_busy", busy, 0);
        send_and_check(8'h5A);
        step();

        // T5: odd parity instance, byte 8'h03
        p_wr_valid = 1'b1;
        p_wr_data  = 8'h03;
        step();
        p_wr_valid = 1'b0;
        check("t5_count", p_fifo_count, 1);
        for (int k = 1; k <= 48; k++) begin
            step();
            check($sformatf("t5_tx_k%0d", k), p_tx, exp_tx(8'h03, k, 2));
            check($sformatf("t5_busy_k%0d", k), p_busy, (k <= 44) ? 1 : 0);
        end

        step();
        check("frames_seen", frames_seen, 13);
        check("sb_final_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
